seg_pipe_adder: RTL
===================

# seg_pipe_adder

Parametrised, pipelined successor to the single-bit full adder. A WIDTH-bit unsigned adder with carry-in is split into STAGES equal slices, one slice per pipeline stage, with the carry registered between stages. Operands and results move over valid/ready handshakes with per-stage backpressure, so the block sustains one addition per clock. It replaces direct full-adder instantiation in datapaths that need wide operands at full clock rate and is driven by the same interface-based class testbench.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of STAGES; ≥ 2.
- STAGES, 4, pipeline depth and slice count; 1 ≤ STAGES ≤ WIDTH; slice width SW = WIDTH/STAGES.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- cin  in  1  carry-in.
- out_valid  out  1  result beat present.
- out_ready  in  1  consumer accepts the result this cycle.
- sum  out  WIDTH  result, a+b+cin modulo 2^WIDTH (see Configuration).
- cout  out  1  carry-out of bit WIDTH-1.
- busy  out  1  any pipeline stage holds a beat.

## Operation
- Stage k (0..STAGES-1) holds: valid_k, the SW-bit partial sums of slices 0..k, the registered carry out of slice k, and the untouched upper operand slices k+1..STAGES-1 of A and B.
- Stage 0 loads on accept: slice 0 = a[SW-1:0] + b[SW-1:0] + cin; carry_0 = carry out of that sum; upper slices of a, b are captured.
- Stage k>0 loads from stage k-1: slice k = A_k + B_k + carry_{k-1}; lower partial sums are copied unchanged.
- The output is stage STAGES-1: sum = concatenated slices, cout = carry_{STAGES-1}, out_valid = valid_{STAGES-1}.
- Handshake per stage: ready_k = !valid_k || ready_{k+1}; ready_{STAGES} = out_ready; in_ready = ready_0. A stage advances (loads) when upstream is valid and ready_k = 1; it clears valid_k when it hands off and receives nothing.
- Transfer occurs only when valid && ready are both high on a rising edge. While in_valid=1 and in_ready=0, the source holds a, b, and cin stable. While out_valid=1 and out_ready=0, sum and cout hold stable.
- Beats exit in acceptance order; none are dropped or duplicated.
- busy = OR of all valid_k.
- STAGES=1 reduces to a single registered full-width adder with the same handshake.

## Timing
- Reset (async assert, release synchronous to clk): all valid_k = 0; out_valid=0, sum=0, cout=0, busy=0. in_ready=1 from the first cycle after reset release.
- Latency: a beat accepted at edge N appears on out_valid after edge N+STAGES-1, i.e. is visible in the cycle following edge N+STAGES-1, when no stalls occur. With STAGES=1, result visible the cycle after accept.
- Throughput: 1 beat/clock with out_ready held high.
- Backpressure: out_ready=0 with a full pipe drives in_ready low combinationally in the same cycle (ready chain is combinational; no skid). A stage may fill a bubble while the output is stalled.
- Simultaneous: out_ready=1 with in_valid=1 on a full pipe — output pops, every stage shifts, and the new beat is accepted in the same edge.
- Reset mid-operation flushes all in-flight beats; they are never emitted.
- Wrap-around: all-ones + all-ones + 1 yields sum = all-ones, cout=1 (non-saturating build).

## Configuration
- Macro SEG_PIPE_ADDER_SAT_EN.
- Defined: unsigned saturation at the output stage. When the final carry is 1, sum is forced to all ones; cout still reports 1. Adds no latency.
- Undefined: sum wraps modulo 2^WIDTH; cout is the raw carry.

## Test plan
- Reset: assert rst mid-stream with 3 beats in flight (WIDTH=8, STAGES=2) → out_valid=0, sum=0, busy=0 immediately; no flushed beat appears after release.
- Cross-slice carry: WIDTH=8, STAGES=2, a=0x0F, b=0x01, cin=0 → sum=0x10, cout=0 after 2 edges; a=0xFF, b=0x00, cin=1 → sum=0x00, cout=1.
- Streaming: 16 back-to-back random beats, out_ready=1 → 16 results in order, one per clock, each matching a+b+cin against the reference model.
- Backpressure: fill the pipe, hold out_ready=0 for 5 cycles → in_ready=0, sum/cout stable; release → beats drain in order with no loss.
- Saturation (macro defined): a=0xF0, b=0x20 → sum=0xFF, cout=1; macro undefined → sum=0x10, cout=1.
- STAGES=1, WIDTH=4: a=0x9, b=0x8, cin=1 → sum=0x2, cout=1 one cycle after accept.

Source files
------------

// File: rtl/seg_pipe_adder.sv
// seg_pipe_adder
//
// Pipelined WIDTH-bit unsigned adder with carry-in. The operands are cut
// into STAGES equal slices of SW = WIDTH/STAGES bits; stage k adds slice k
// using the carry registered by stage k-1. Every stage has a valid/ready
// handshake, so the pipe sustains one addition per clock and stalls cleanly.
//
// Optional feature (macro SEG_PIPE_ADDER_SAT_EN):
//   defined   -> the result saturates to all ones whenever the final carry is 1
//                (cout still reports 1).
//   undefined -> the result wraps modulo 2^WIDTH and cout is the raw carry.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand beat present
//   in_ready   block accepts a beat this cycle
//   a, b       WIDTH-bit unsigned operands
//   cin        carry-in
//   out_valid  result beat present
//   out_ready  consumer accepts the result this cycle
//   sum        WIDTH-bit result
//   cout       carry out of bit WIDTH-1
//   busy       any stage holds a beat

module seg_pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int SW = WIDTH / STAGES;

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] carry_q, carry_d;
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_d [STAGES];
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  a_d   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  b_d   [STAGES];
  logic [STAGES:0]   ready;
  logic [SW:0]       add_tmp;

  // Ready chain runs backwards from the consumer: a stage can take a beat if
  // it is empty or if its own beat leaves this cycle. Purely combinational,
  // so a stalled output propagates to in_ready in the same cycle.
  always_comb begin
    ready[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ready[k] = !valid_q[k] || ready[k+1];
    end
  end

  // Next-state for every stage. A ready stage takes whatever its upstream
  // offers (possibly nothing, which clears its valid); a stalled stage holds.
  // Slices below the current one are copied, slice k is computed here, and
  // the full operand words travel along so later stages can pick their slice.
  always_comb begin
    valid_d = valid_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    a_d     = a_q;
    b_d     = b_q;
    add_tmp = '0;

    if (ready[0]) begin
      valid_d[0] = in_valid;
      if (in_valid) begin
        add_tmp = {1'b0, a[SW-1:0]} + {1'b0, b[SW-1:0]} + {{SW{1'b0}}, cin};
        sum_d[0]          = '0;
        sum_d[0][SW-1:0]  = add_tmp[SW-1:0];
        carry_d[0]        = add_tmp[SW];
        a_d[0]            = a;
        b_d[0]            = b;
      end
    end

    for (int k = 1; k < STAGES; k++) begin
      if (ready[k]) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) begin
          add_tmp = {1'b0, a_q[k-1][k*SW +: SW]} + {1'b0, b_q[k-1][k*SW +: SW]}
                    + {{SW{1'b0}}, carry_q[k-1]};
          sum_d[k]             = sum_q[k-1];
          sum_d[k][k*SW +: SW] = add_tmp[SW-1:0];
          carry_d[k]           = add_tmp[SW];
          a_d[k]               = a_q[k-1];
          b_d[k]               = b_q[k-1];
        end
      end
    end
  end

  // Pipeline registers. Reset clears data as well as valids so the output
  // port reads zero while the pipe is empty after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      carry_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  assign in_ready  = ready[0];
  assign out_valid = valid_q[STAGES-1];
  assign cout      = carry_q[STAGES-1];
  assign busy      = |valid_q;

`ifdef SEG_PIPE_ADDER_SAT_EN
  // Saturation is a mux on registered values, so it adds no latency and the
  // output stays stable while the last stage is stalled.
  assign sum = carry_q[STAGES-1] ? {WIDTH{1'b1}} : sum_q[STAGES-1];
`else
  assign sum = sum_q[STAGES-1];
`endif

endmodule
